mem_stage_pipe: RTL
===================

Name: mem_stage_pipe

Overview:
Parametrised RISC-V memory stage with MEM/WB pipeline register. Supports byte/half/word loads and stores, with sign/zero extension selected by funct3. Has a configurable-latency internal data RAM and drives a stall handshake back to the upstream pipeline. Sits between the EX/MEM register and the writeback mux.

Parameters:
DEPTH, 64, number of 32-bit words in the data RAM; power of two, at least 4.
MEM_LAT, 0, extra wait cycles per load/store; 0 gives a single-cycle access, and the range is 0..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low
RegWriteM  in  1  register write enable from MEM
MemWriteM  in  1  store request
MemReadM  in  1  load request
ResultSrcM  in  1  writeback select, passed through
Funct3M  in  3  access size and sign (RV32I encoding)
RD_M  in  5  destination register
PCPlus4M  in  32  PC+4, passed through
WriteDataM  in  32  store data, right-aligned
ALU_Result_M  in  32  byte address / ALU result
StallM  out  1  access in progress; upstream must hold all M inputs stable
RegWriteW  out  1  registered
ResultSrcW  out  1  registered
RD_W  out  5  registered
PCPlus4W  out  32  registered
ALU_ResultW  out  32  registered
ReadDataW  out  32  registered, extended load data
MisalignW  out  1  registered misaligned-access flag

Behaviour:
- Reset (rst=0, async):
  - All W outputs go to 0.
  - FSM goes to IDLE and the wait counter clears.
  - An in-flight access is abandoned and no write is committed.
  - RAM contents are not reset.
- Addressing:
  - word index = ALU_Result_M[log2(DEPTH)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- Access classification:
  - MemWriteM=1 is a store; it has priority when MemReadM=1 at the same time, and ReadDataW is then 0.
  - MemReadM=1 alone is a load.
  - Neither set means no access.
- Store byte enables:
  - funct3 000 (SB): lane addr[1:0] gets WriteDataM[7:0].
  - funct3 001 (SH): lanes {addr[1],0} and {addr[1],1} get WriteDataM[15:0].
  - funct3 010 (SW): all four lanes.
  - Any other funct3 is treated as SW.
- Load extraction from the addressed word:
  - 000 LB: byte, sign-extended.
  - 001 LH: half, sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - Other funct3 values are treated as LW.
- FSM states: IDLE, BUSY.
  - MEM_LAT=0: never leaves IDLE. StallM=0. The RAM is written on the same edge that captures the W register. Combinational read, identical to a single-cycle stage.
  - MEM_LAT>0, access in IDLE: StallM=1 combinationally. Next state is BUSY with cnt=MEM_LAT-1.
  - In BUSY: StallM=1 while cnt!=0, and cnt decrements each cycle.
  - When cnt==0: StallM=0. The write commits (exactly once), read data is sampled, the W register captures the instruction, and the FSM returns to IDLE.
  - A load/store therefore occupies MEM_LAT+1 cycles. Non-memory instructions never stall.
- W register:
  - On each edge with StallM=0, it captures the M-side fields plus extended read data.
  - On each edge with StallM=1, it loads a bubble: RegWriteW=0, MisalignW=0, other fields 0.
- Back-to-back accesses: each pays the full latency. There is no overlap between accesses.
- MisalignW:
  - Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - Handling depends on the macro below.

Optional Feature:
MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access sets MisalignW=1 in the captured W entry.
  - The store's RAM write is suppressed.
  - RegWriteW is forced to 0 and ReadDataW is 0.
  - Latency is unchanged.
- Undefined:
  - Low address bits below the access size are ignored, i.e. the access is aligned down.
  - MisalignW is tied to 0.

Test Plan:
- Reset mid-BUSY (MEM_LAT=3): SW 0xDEADBEEF to 0x10, assert rst in cycle 2, release, then LW 0x10 → old RAM value returned; all W outputs 0 during reset; StallM=0 after reset.
- MEM_LAT=0: SW 0x11223344 to 0x08, then LB from 0x0B → ReadDataW=0x00000011. LH from 0x0A → 0x00001122. LBU from 0x08 → 0x44. StallM never asserted.
- Sign extension: SB 0x80 to 0x04, then LB 0x04 → 0xFFFFFF80. LBU 0x04 → 0x00000080. SH 0x8001 to 0x06, then LH 0x06 → 0xFFFF8001.
- MEM_LAT=2:
  - LW 0x00 → StallM high for exactly 2 cycles, W bubbles (RegWriteW=0) on those edges, data captured on the 3rd edge.
  - An ALU op following it → no stall.
- Wrap (DEPTH=64): SW 0xCAFEF00D to 0x104 → LW 0x004 returns 0xCAFEF00D.
- Misaligned:
  - With macro: SW to 0x02 → MisalignW=1, RegWriteW=0, and a later LW 0x00 is unchanged.
  - Without macro: LW 0x02 returns the word at 0x00, with MisalignW=0.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: RV32 memory stage with configurable-latency data RAM and MEM/WB register.
// Optional MEM_STAGE_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them down.
module mem_stage_pipe #(
    parameter int DEPTH   = 64,
    parameter int MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic        ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_Result_M,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        MisalignW
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]  a, off;
    logic [3:0]  be;
    logic [31:0] wdat, rword, sh, ext;
    logic        acc, ld, by, hw, mis, trap, we;
    assign a     = ALU_Result_M[1:0];
    assign idx   = ALU_Result_M[AW+1:2];
    assign acc   = MemWriteM | MemReadM;
    assign ld    = MemReadM & ~MemWriteM;
    // store sizes decode only 000/001; load sizes ignore the unsigned bit
    assign by    = MemWriteM ? Funct3M == 3'b000 : Funct3M[1:0] == 2'b00;
    assign hw    = MemWriteM ? Funct3M == 3'b001 : Funct3M[1:0] == 2'b01;
    assign mis   = acc & ((hw & a[0]) | (~hw & ~by & (a != 2'b00)));
    assign off   = by ? a : hw ? {a[1], 1'b0} : 2'b00;
    assign be    = by ? 4'b0001 << off : hw ? 4'b0011 << off : 4'b1111;
    assign wdat  = by ? {4{WriteDataM[7:0]}} : hw ? {2{WriteDataM[15:0]}} : WriteDataM;
    assign rword = mem_q[idx];
    assign sh    = rword >> {off, 3'b000};
    assign ext   = by ? {{24{~Funct3M[2] & sh[7]}}, sh[7:0]} :
                   hw ? {{16{~Funct3M[2] & sh[15]}}, sh[15:0]} : rword;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign trap  = mis;
`else
    assign trap  = 1'b0;
`endif
    assign we    = rst & MemWriteM & ~StallM & ~trap;
    logic unused;
    assign unused = ^{ALU_Result_M[31:AW+2], mis};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallM  = 1'b0;
        if (MEM_LAT != 0) begin
            if (state_q == IDLE) begin
                if (acc) begin
                    StallM  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 4'(MEM_LAT - 1);
                end
            end else if (cnt_q != 4'd0) begin
                StallM = 1'b1;
                cnt_d  = cnt_q - 4'd1;
            end else begin
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            MisalignW   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            RegWriteW   <= ~StallM & RegWriteM & ~trap;
            ResultSrcW  <= ~StallM & ResultSrcM;
            RD_W        <= StallM ? 5'd0 : RD_M;
            PCPlus4W    <= StallM ? 32'd0 : PCPlus4M;
            ALU_ResultW <= StallM ? 32'd0 : ALU_Result_M;
            ReadDataW   <= (~StallM & ld & ~trap) ? ext : 32'd0;
            MisalignW   <= ~StallM & trap;
        end
    end
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[idx][8*i +: 8] <= wdat[8*i +: 8];
    end
endmodule
